// File: rtl/cnn_stream_scheduler.sv
// Frame streaming sequencer: reads one IMG_W x IMG_H frame into the pixel path and
// writes datapath results back, arbitrating both over a single OBI-style manager port.
module cnn_stream_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] input_base_i,
    input  logic [ADDR_WIDTH-1:0] output_base_i,
    input  logic [CNT_WIDTH-1:0]  out_count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    input  logic                  res_valid_i,
    output logic                  res_ready_o,
    input  logic [31:0]           res_data_i
);

    localparam logic [CNT_WIDTH-1:0] NUM_PIX = CNT_WIDTH'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_RD,
        S_RWAIT,
        S_WR,
        S_WWAIT
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] in_base;
    logic [ADDR_WIDTH-1:0] out_base;
    logic [CNT_WIDTH-1:0]  out_count;
    logic [CNT_WIDTH-1:0]  rd_cnt;
    logic [CNT_WIDTH-1:0]  wr_cnt;
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  res_full;
    logic [31:0]           res_data;
    logic                  done;
    logic                  err;
    logic                  abort_pend;

    logic start_acc;
    logic abort_now;
    logic resp_ok;
    logic resp_err;
    logic complete;
    logic res_room;
    logic flush;
    logic rd_load;
    logic wr_retire;

    // Only the low pixel lane of a read word feeds the datapath.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata_i[31:DATA_WIDTH];

    assign start_acc = (state == S_IDLE) && start_i;
    assign abort_now = abort_pend || abort_i;
    assign resp_ok   = mem_rvalid_i && !mem_err_i;
    assign resp_err  = mem_rvalid_i && mem_err_i && ((state == S_RWAIT) || (state == S_WWAIT));
    assign rd_load   = (state == S_RWAIT) && resp_ok;
    assign wr_retire = (state == S_WWAIT) && resp_ok;
    assign flush     = (state == S_ARB) && abort_now;

    assign complete = (rd_cnt == NUM_PIX) && !pix_valid && !res_full && (wr_cnt == out_count);
    assign res_room = ({1'b0, wr_cnt} + (CNT_WIDTH+1)'(res_full)) < {1'b0, out_count};

    assign busy_o      = (state != S_IDLE);
    assign done_o      = done;
    assign err_o       = err;
    assign mem_be_o    = 4'hF;
    assign pix_valid_o = pix_valid;
    assign pix_data_o  = pix_data;
    // Results are refused once the frame is winding down after an abort or error.
    assign res_ready_o = busy_o && !abort_pend && !res_full && res_room;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_ARB;
            end
            S_ARB: begin
                if (abort_now)                          state_nxt = S_IDLE;
                else if (res_full)                      state_nxt = S_WR;
                else if ((rd_cnt < NUM_PIX) && !pix_valid) state_nxt = S_RD;
                else if (complete)                      state_nxt = S_IDLE;
            end
            S_RD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = in_base + (ADDR_WIDTH'(rd_cnt) << 2);
                if (mem_gnt_i) state_nxt = S_RWAIT;
            end
            S_RWAIT: begin
                if (mem_rvalid_i) state_nxt = mem_err_i ? S_IDLE : S_ARB;
            end
            S_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = out_base + (ADDR_WIDTH'(wr_cnt) << 2);
                mem_wdata_o = res_data;
                if (mem_gnt_i) state_nxt = S_WWAIT;
            end
            S_WWAIT: begin
                if (mem_rvalid_i) state_nxt = mem_err_i ? S_IDLE : S_ARB;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_base    <= '0;
            out_base   <= '0;
            out_count  <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            if (start_acc) begin
                in_base   <= input_base_i;
                out_base  <= output_base_i;
                out_count <= out_count_i;
                rd_cnt    <= '0;
                wr_cnt    <= '0;
                done      <= 1'b0;
                err       <= 1'b0;
            end
            if (rd_load)   rd_cnt <= rd_cnt + CNT_WIDTH'(1);
            if (wr_retire) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            if (resp_err)  err <= 1'b1;
            if ((state == S_ARB) && !abort_now && (state_nxt == S_IDLE)) done <= 1'b1;
            // A pending abort is consumed by the return to IDLE.
            if ((state != S_IDLE) && abort_i) abort_pend <= 1'b1;
            if ((state != S_IDLE) && (state_nxt == S_IDLE)) abort_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else if (start_acc || flush) begin
            pix_valid <= 1'b0;
        end else if (rd_load) begin
            pix_valid <= 1'b1;
            pix_data  <= mem_rdata_i[DATA_WIDTH-1:0];
        end else if (pix_valid && pix_ready_i) begin
            pix_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_full <= 1'b0;
            res_data <= '0;
        end else if (start_acc || flush || wr_retire) begin
            res_full <= 1'b0;
        end else if (res_valid_i && res_ready_o) begin
            res_full <= 1'b1;
            res_data <= res_data_i;
        end
    end

endmodule

// File: doc/cnn_stream_scheduler.md
# cnn_stream_scheduler

Sequencer for the CNN conv/ReLU/pool datapath. On a start command it streams one IMG_W×IMG_H input frame from memory into the pixel input of the datapath. It also collects result words from the datapath output and writes them back to memory. Reads and writes share one OBI-style manager port, and this block arbitrates between them. It sits between the accelerator register file (bases, start, count) and the line buffer / ReLU / pool chain.

## Interface
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 8, pixel width
- IMG_W, 28, frame width in pixels
- IMG_H, 28, frame height in pixels
- CNT_WIDTH, 16, width of pixel/result counters
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start pulse; sampled only in IDLE
- abort_i  in  1  abort request; sampled when busy
- input_base_i  in  ADDR_WIDTH  frame base; latched at start
- output_base_i  in  ADDR_WIDTH  result base; latched at start
- out_count_i  in  CNT_WIDTH  results to write; latched at start
- busy_o  out  1  state != IDLE
- done_o  out  1  sticky; frame completed; cleared by next accepted start
- err_o  out  1  sticky; mem_err_i seen; cleared by next accepted start
- mem_req_o  out  1  manager request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_WIDTH  word address
- mem_wdata_o  out  32  write data
- mem_be_o  out  4  byte enables, always 4'hF
- mem_gnt_i  in  1  grant
- mem_rvalid_i  in  1  response valid, for reads and writes
- mem_rdata_i  in  32  read data
- mem_err_i  in  1  response error, qualified by mem_rvalid_i
- pix_valid_o  out  1  pixel to line buffer valid
- pix_ready_i  in  1  line buffer ready
- pix_data_o  out  DATA_WIDTH  pixel = mem_rdata_i[DATA_WIDTH-1:0]
- res_valid_i  in  1  datapath result valid
- res_ready_o  out  1  result accepted
- res_data_i  in  32  result word

## Operation
- FSM states:
  - IDLE: start_i → ARB. Latches bases and out_count_i, clears rd_cnt, wr_cnt, done_o and err_o.
  - ARB: picks the next transaction.
    - If res_full → WR (writes have priority).
    - Else if rd_cnt < IMG_W*IMG_H, pix register empty, and abort not pending → RD.
    - Else if completion holds → IDLE with done_o=1.
    - Else stays in ARB.
  - RD: mem_req_o=1, we=0, addr = input_base + 4*rd_cnt. On mem_gnt_i → RWAIT.
  - RWAIT: on mem_rvalid_i, loads the pix register, rd_cnt++ → ARB.
  - WR: mem_req_o=1, we=1, addr = output_base + 4*wr_cnt, wdata = res buffer. On mem_gnt_i → WWAIT.
  - WWAIT: on mem_rvalid_i, clears res_full, wr_cnt++ → ARB.
- Only one memory transaction is outstanding at a time. mem_addr_o, mem_we_o and mem_wdata_o stay stable while mem_req_o && !mem_gnt_i.
- Pixel register runs independently of the FSM. pix_valid_o holds until pix_ready_i. Data is unchanged while valid.
- Result buffer (1 entry): res_ready_o = !res_full && (wr_cnt + res_full) < out_count. A handshake sets res_full.
- Completion: rd_cnt == IMG_W*IMG_H, pix register empty, !res_full, wr_cnt == out_count.
- mem_err_i with mem_rvalid_i: err_o=1, then → IDLE. No data is loaded, counters are not incremented, and done_o stays 0.
- abort_i: sets abort_pend. Any transaction in RD/WR/RWAIT/WWAIT completes normally, then → IDLE. Pix and res buffers are flushed and done_o stays 0.
- start_i while busy: ignored.
- out_count_i = 0: frame is read only, res_ready_o stays 0.
- Counters do not wrap; IMG_W*IMG_H must be < 2^CNT_WIDTH.

## Timing
- Reset values: busy_o, done_o, err_o, mem_req_o, mem_we_o, pix_valid_o, res_ready_o = 0. mem_addr_o, mem_wdata_o, pix_data_o = 0. mem_be_o = 4'hF.
- start_i sampled at edge t: busy_o=1 from t+1 (ARB), first mem_req_o at t+2.
- Read with zero-wait gnt and rvalid one cycle later: pix_valid_o rises 1 cycle after the mem_rvalid_i edge.
- Minimum per-pixel read period: 4 cycles (ARB, RD, RWAIT, load).
- done_o rises 1 cycle after the ARB cycle in which completion holds, and busy_o falls in the same cycle.
- The FSM updates (load and state change) at the same edge that completes an rvalid in RWAIT or WWAIT.
- Reset mid-operation: all state returns immediately to reset values. An outstanding memory response after reset is ignored.

## Test plan
- IMG_W=IMG_H=4, out_count=0, zero-wait memory, pix_ready_i=1 → 16 reads at addresses base, base+4 … base+60. Pixels are emitted in order; done_o=1, err_o=0.
- IMG 4×4, out_count=4, a result injected after pixel 10 → the write goes to output_base+0 before the next read (priority). After all 4 writes, done_o=1 and wr_cnt=4.
- Grant delayed 3 cycles and pix_ready_i toggling 50% → mem_addr_o stays stable while waiting for gnt. The pixel sequence is unchanged and no pixel is lost.
- mem_err_i on read 5 → err_o=1, back in IDLE 1 cycle later, done_o=0, and only 4 pixels emitted.
- abort_i while in RD with gnt stalled → the request stays asserted until gnt, then rvalid, then IDLE with done_o=0. A new start then runs the full frame.
- start_i while busy and rst_i mid-frame → the extra start has no effect. Reset forces all outputs to reset values within the same cycle.
